bch1572_codec: RTL and testbench
================================

Name: bch1572_codec

Overview:
Registered systematic (15,7) block codec with encode and decode paths sharing one clock. The code is the team's "BCH(15,7,2)" code as defined by the parity equations below. The encoder appends 8 parity bits to 7 data bits. The decoder computes an 8-bit syndrome, corrects any single-bit error, and flags uncorrectable patterns. It sits between the payload datapath and the storage/link interface.

Parameters:
None. Code geometry is fixed: n=15, k=7, 8 parity bits.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
enc_valid_in  in  1  data_in qualifier
data_in  in  7  message bits d6..d0
enc_valid_out  out  1  codeword_out valid
codeword_out  out  15  {d6..d0, p7..p0}
dec_valid_in  in  1  codeword_in qualifier
codeword_in  in  15  received word, [14:8]=data, [7:0]=parity
dec_valid_out  out  1  decoder outputs valid
data_out  out  7  corrected message
error_detected  out  1  syndrome nonzero
error_corrected  out  1  single error located and fixed
error_count  out  2  0=none, 1=single corrected, 2=uncorrectable, 3 unused

Behaviour:
- Reset: when rst=1 at a clock edge, every output register clears to 0, including valids, codeword_out, data_out, flags and error_count. Reset wins over a simultaneous valid_in.
- Encoder latency is 1 cycle. When enc_valid_in=1, the next edge loads codeword_out, with codeword_out[14:8]=data_in, and sets enc_valid_out=1. When enc_valid_in=0, enc_valid_out goes 0 and codeword_out holds its value.
- Parity equations (^ is XOR):
  - p7 = d6^d5^d4^d2
  - p6 = d6^d5^d3^d1
  - p5 = d6^d4^d3^d0
  - p4 = d5^d4^d2^d1
  - p3 = d6^d5^d3^d2^d0
  - p2 = d6^d4^d3^d1^d0
  - p1 = d5^d4^d2^d1^d0
  - p0 = d6^d5^d4^d3^d2^d1^d0
- Decoder latency is 1 cycle, with the same valid/hold rules as the encoder.
- Syndrome S[7:0] = parity recomputed from codeword_in[14:8], XOR codeword_in[7:0].
- H columns (S value for a single flipped bit):
  - parity bit i -> one-hot (1<<i)
  - d6=0xED, d5=0xDB, d4=0xB7, d3=0x6D, d2=0x9B, d1=0x57, d0=0x2F
- Decoder outputs by syndrome:
  - S==0: error_detected=0, error_corrected=0, error_count=0, data_out=codeword_in[14:8].
  - S matches a data column: the matching data bit is flipped in data_out; detected=1, corrected=1, count=1.
  - S one-hot (parity-bit error): data_out = raw data; detected=1, corrected=1, count=1.
  - Any other nonzero S: data_out = raw data; detected=1, corrected=0, count=2.
- Minimum distance is 3 (d6+d3+p7 is a weight-3 codeword). Guaranteed behaviour is single-error correction only. Double errors either flag count=2 or miscorrect. A miscorrection is required behaviour, not a bug.
- Encode and decode paths are independent and may be active in the same cycle.
- Back-to-back valid inputs produce back-to-back outputs, one per cycle, with no stalls.

Test Plan:
- Reset: assert rst with both valid_in=1 -> next cycle all outputs 0. Deassert rst -> normal operation on the following edge.
- Encode 0x5B (1011011) -> codeword_out=0x5B4F. Encode 0x7F -> 0x7F0F. Encode 0x00 -> 0x0000. Encode ten vectors 0x55+7i, i=0..9 -> each matches the parity equations.
- Decode 0x5B4F clean -> data_out=0x5B, detected=0, corrected=0, count=0.
- Decode 0x5B4F with each single bit i=0..14 flipped -> data_out=0x5B, detected=1, corrected=1, count=1 for all 15 positions.
- Decode 0x5B4F with bits 0 and 1 flipped (S=0x03) -> data_out=0x5B, detected=1, corrected=0, count=2.
- Decode 0x5B4F with bits 14 and 11 flipped (S=0x80) -> miscorrected as p7: data_out=0x13, corrected=1, count=1.
- Back-to-back decode plus a dec_valid_in gap -> dec_valid_out follows with 1-cycle lag, and outputs hold during the gap.

Source files
------------

// File: rtl/bch1572_codec_if.sv
// Bus bundle for the BCH(15,7) codec: one encode channel and one decode channel.
//
// Handshake: each channel is valid-only. The codec is always ready, so a
// word is transferred on every rising edge where its *_valid_in is 1. The
// matching result appears one edge later with *_valid_out=1 for exactly one
// cycle. While *_valid_out=0 the result fields keep their last value.
interface bch1572_codec_if;
  logic        enc_valid_in;
  logic [6:0]  data_in;
  logic        enc_valid_out;
  logic [14:0] codeword_out;

  logic        dec_valid_in;
  logic [14:0] codeword_in;
  logic        dec_valid_out;
  logic [6:0]  data_out;
  logic        error_detected;
  logic        error_corrected;
  logic [1:0]  error_count;

  // Traffic source / sink side (testbench or upstream datapath).
  modport master (
    output enc_valid_in, data_in, dec_valid_in, codeword_in,
    input  enc_valid_out, codeword_out, dec_valid_out, data_out,
           error_detected, error_corrected, error_count
  );

  // Codec side.
  modport slave (
    input  enc_valid_in, data_in, dec_valid_in, codeword_in,
    output enc_valid_out, codeword_out, dec_valid_out, data_out,
           error_detected, error_corrected, error_count
  );
endinterface

// File: rtl/bch1572_codec.sv
// Registered systematic (15,7) codec. Encoder appends 8 parity bits;
// decoder builds an 8-bit syndrome, repairs any single-bit error and flags
// everything else it cannot place. Both paths have 1-cycle latency, run
// independently and accept a new word every cycle.
module bch1572_codec (
  input  logic            clk,
  input  logic            rst,
  bch1572_codec_if.slave  bus
);

  // Parity bits p7..p0 for message d6..d0.
  function automatic logic [7:0] parity_of(input logic [6:0] d);
    logic [7:0] p;
    p[7] = d[6] ^ d[5] ^ d[4] ^ d[2];
    p[6] = d[6] ^ d[5] ^ d[3] ^ d[1];
    p[5] = d[6] ^ d[4] ^ d[3] ^ d[0];
    p[4] = d[5] ^ d[4] ^ d[2] ^ d[1];
    p[3] = d[6] ^ d[5] ^ d[3] ^ d[2] ^ d[0];
    p[2] = d[6] ^ d[4] ^ d[3] ^ d[1] ^ d[0];
    p[1] = d[5] ^ d[4] ^ d[2] ^ d[1] ^ d[0];
    p[0] = d[6] ^ d[5] ^ d[4] ^ d[3] ^ d[2] ^ d[1] ^ d[0];
    return p;
  endfunction

  logic        enc_valid_q;
  logic [14:0] codeword_q;
  logic        dec_valid_q;
  logic [6:0]  data_q;
  logic        detected_q;
  logic        corrected_q;
  logic [1:0]  count_q;

  logic [6:0]  raw_data;
  logic [7:0]  syndrome;
  logic [6:0]  flip_mask;
  logic        syn_is_data;
  logic        syn_is_parity;

  // Syndrome and error location. A data-bit error matches one H column; a
  // parity-bit error gives a one-hot syndrome and leaves the data untouched.
  always_comb begin
    raw_data    = bus.codeword_in[14:8];
    syndrome    = parity_of(raw_data) ^ bus.codeword_in[7:0];
    flip_mask   = 7'h00;
    syn_is_data = 1'b0;
    case (syndrome)
      8'hED: begin flip_mask = 7'h40; syn_is_data = 1'b1; end
      8'hDB: begin flip_mask = 7'h20; syn_is_data = 1'b1; end
      8'hB7: begin flip_mask = 7'h10; syn_is_data = 1'b1; end
      8'h6D: begin flip_mask = 7'h08; syn_is_data = 1'b1; end
      8'h9B: begin flip_mask = 7'h04; syn_is_data = 1'b1; end
      8'h57: begin flip_mask = 7'h02; syn_is_data = 1'b1; end
      8'h2F: begin flip_mask = 7'h01; syn_is_data = 1'b1; end
      default: begin
        flip_mask   = 7'h00;
        syn_is_data = 1'b0;
      end
    endcase
    syn_is_parity = (syndrome != 8'h00) &&
                    ((syndrome & (syndrome - 8'd1)) == 8'h00);
  end

  // Encoder register: load on valid, otherwise hold the last codeword.
  always_ff @(posedge clk) begin
    if (rst) begin
      enc_valid_q <= 1'b0;
      codeword_q  <= 15'h0000;
    end else begin
      enc_valid_q <= bus.enc_valid_in;
      if (bus.enc_valid_in) begin
        codeword_q <= {bus.data_in, parity_of(bus.data_in)};
      end
    end
  end

  // Decoder register: corrected data plus status, held while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      dec_valid_q <= 1'b0;
      data_q      <= 7'h00;
      detected_q  <= 1'b0;
      corrected_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      dec_valid_q <= bus.dec_valid_in;
      if (bus.dec_valid_in) begin
        data_q     <= raw_data ^ flip_mask;
        detected_q <= (syndrome != 8'h00);
        if (syndrome == 8'h00) begin
          corrected_q <= 1'b0;
          count_q     <= 2'd0;
        end else if (syn_is_data || syn_is_parity) begin
          corrected_q <= 1'b1;
          count_q     <= 2'd1;
        end else begin
          corrected_q <= 1'b0;
          count_q     <= 2'd2;
        end
      end
    end
  end

  assign bus.enc_valid_out   = enc_valid_q;
  assign bus.codeword_out    = codeword_q;
  assign bus.dec_valid_out   = dec_valid_q;
  assign bus.data_out        = data_q;
  assign bus.error_detected  = detected_q;
  assign bus.error_corrected = corrected_q;
  assign bus.error_count     = count_q;

endmodule

// File: tb/tb_bch1572_codec.sv
// Testbench for bch1572_codec: directed vectors with known answers, then
// randomized traffic checked against a generator-matrix / brute-force model.
module tb_bch1572_codec;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bch1572_codec_if bus();

  bch1572_codec dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   cyc = 0;
  logic rst_q;
  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  // ---------------- scoreboard state ----------------
  logic [14:0] enc_exp_q[$];
  int          enc_t_q[$];
  logic [10:0] dec_exp_q[$];   // {data[6:0], detected, corrected, count[1:0]}
  int          dec_t_q[$];
  logic [14:0] last_cw  = '0;
  logic [10:0] last_dec = '0;
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model ----------------
  // H column for each message bit d0..d6; each generator row is the data bit
  // itself plus its column, and a codeword is the XOR of the selected rows.
  localparam logic [7:0] H_COL [0:6] = '{8'h2F, 8'h57, 8'h9B, 8'h6D, 8'hB7, 8'hDB, 8'hED};

  function automatic logic [14:0] model_encode(input logic [6:0] d);
    logic [14:0] cw = '0;
    for (int j = 0; j < 7; j++)
      if (d[j]) cw ^= (15'(1) << (j + 8)) | 15'(H_COL[j]);
    return cw;
  endfunction

  function automatic logic [10:0] pack_dec(input logic [6:0] d, input logic det,
                                           input logic cor, input logic [1:0] cnt);
    return {d, det, cor, cnt};
  endfunction

  // Decode by search: a clean word is already a codeword; a single error is
  // the unique one-bit flip that lands on a codeword; anything else is flagged.
  function automatic logic [10:0] model_decode(input logic [14:0] r);
    logic [14:0] t;
    if (model_encode(r[14:8]) == r) return pack_dec(r[14:8], 1'b0, 1'b0, 2'd0);
    for (int i = 0; i < 15; i++) begin
      t = r ^ (15'(1) << i);
      if (model_encode(t[14:8]) == t) return pack_dec(t[14:8], 1'b1, 1'b1, 2'd1);
    end
    return pack_dec(r[14:8], 1'b1, 1'b0, 2'd2);
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input logic ev, input logic [6:0] d, input logic [14:0] e_exp,
                       input logic dv, input logic [14:0] cw, input logic [10:0] d_exp);
    bus.enc_valid_in = ev;
    bus.data_in      = d;
    bus.dec_valid_in = dv;
    bus.codeword_in  = cw;
    if (!rst) begin
      if (ev) begin enc_exp_q.push_back(e_exp); enc_t_q.push_back(cyc + 1); end
      if (dv) begin dec_exp_q.push_back(d_exp); dec_t_q.push_back(cyc + 1); end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic enc_dir(input logic [6:0] d, input logic [14:0] e_exp);
    drive(1'b1, d, e_exp, 1'b0, 15'($urandom), '0);
  endtask

  task automatic dec_dir(input logic [14:0] cw, input logic [10:0] d_exp);
    drive(1'b0, 7'($urandom), '0, 1'b1, cw, d_exp);
  endtask

  task automatic idle();
    drive(1'b0, 7'($urandom), '0, 1'b0, 15'($urandom), '0);
  endtask

  // ---------------- monitor ----------------
  // Sampled on the falling edge, half a cycle after outputs update.
  always @(negedge clk) begin
    if (rst_q === 1'b1) begin
      check("rst_enc_valid", bus.enc_valid_out, 0);
      check("rst_codeword", bus.codeword_out, 0);
      check("rst_dec_valid", bus.dec_valid_out, 0);
      check("rst_dec_fields", {bus.data_out, bus.error_detected, bus.error_corrected,
                               bus.error_count}, 0);
      last_cw  = '0;
      last_dec = '0;
    end else if (rst_q === 1'b0) begin
      if (enc_exp_q.size() != 0 && enc_t_q[0] == cyc) begin
        check("enc_valid_out", bus.enc_valid_out, 1);
        check("codeword_out", bus.codeword_out, enc_exp_q[0]);
        last_cw = enc_exp_q[0];
        void'(enc_exp_q.pop_front());
        void'(enc_t_q.pop_front());
      end else begin
        check("enc_valid_idle", bus.enc_valid_out, 0);
        check("codeword_hold", bus.codeword_out, last_cw);
      end
      if (dec_exp_q.size() != 0 && dec_t_q[0] == cyc) begin
        check("dec_valid_out", bus.dec_valid_out, 1);
        check("dec_fields", {bus.data_out, bus.error_detected, bus.error_corrected,
                             bus.error_count}, dec_exp_q[0]);
        last_dec = dec_exp_q[0];
        void'(dec_exp_q.pop_front());
        void'(dec_t_q.pop_front());
      end else begin
        check("dec_valid_idle", bus.dec_valid_out, 0);
        check("dec_hold", {bus.data_out, bus.error_detected, bus.error_corrected,
                           bus.error_count}, last_dec);
      end
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [14:0] cw;
    logic [6:0]  d;
    bus.enc_valid_in = 1'b0;
    bus.data_in      = '0;
    bus.dec_valid_in = 1'b0;
    bus.codeword_in  = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Load something nonzero, then reset with both valids high: reset wins.
    drive(1'b1, 7'h7F, 15'h7F0F, 1'b1, 15'h5B4C, pack_dec(7'h5B, 1'b1, 1'b0, 2'd2));
    rst = 1'b1;
    drive(1'b1, 7'h2A, '0, 1'b1, 15'h7FFF, '0);
    rst = 1'b0;

    // Encoder known answers.
    enc_dir(7'h5B, 15'h5B4F);
    enc_dir(7'h7F, 15'h7F0F);
    enc_dir(7'h00, 15'h0000);
    for (int i = 0; i < 10; i++) begin
      d = 7'(8'h55 + 8'(7 * i));
      enc_dir(d, model_encode(d));
    end

    // Decoder: clean word, every single-bit error, a flagged double, a miscorrection.
    dec_dir(15'h5B4F, pack_dec(7'h5B, 1'b0, 1'b0, 2'd0));
    for (int i = 0; i < 15; i++)
      dec_dir(15'h5B4F ^ (15'(1) << i), pack_dec(7'h5B, 1'b1, 1'b1, 2'd1));
    dec_dir(15'h5B4C, pack_dec(7'h5B, 1'b1, 1'b0, 2'd2));
    dec_dir(15'h134F, pack_dec(7'h13, 1'b1, 1'b1, 2'd1));

    // Back-to-back decodes, a two-cycle gap (outputs hold), then one more.
    dec_dir(15'h5B4F, pack_dec(7'h5B, 1'b0, 1'b0, 2'd0));
    dec_dir(15'h5B47, pack_dec(7'h5B, 1'b1, 1'b1, 2'd1));
    idle();
    idle();
    dec_dir(15'h7F0F, pack_dec(7'h7F, 1'b0, 1'b0, 2'd0));
    idle();

    // Random concurrent traffic with gaps and 0/1/2 bit errors.
    for (int n = 0; n < 300; n++) begin
      logic ev, dv;
      logic [6:0] ed;
      int flips;
      ev = ($urandom_range(0, 3) != 0);
      dv = ($urandom_range(0, 3) != 0);
      ed = 7'($urandom);
      cw = model_encode(7'($urandom));
      flips = $urandom_range(0, 2);
      for (int k = 0; k < flips; k++)
        cw ^= 15'(1) << $urandom_range(0, 14);
      drive(ev, ed, model_encode(ed), dv, cw, model_decode(cw));
    end

    repeat (3) idle();
    check("enc_queue_drained", enc_exp_q.size(), 0);
    check("dec_queue_drained", dec_exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
